// File: rtl/accum_normalize.sv
// rtl/accum_normalize.sv - accumulates beats of nine aligned partial products per group, then normalizes the group sum
//
// Purpose: sums nine signed 16-bit aligned partial products per beat into a
// 28-bit accumulator over a group of 1..256 beats. It then emits the result as
// sign / exponent / 11-bit mantissa with the leading one at bit 10.
//
// Ports:
//   clk                         clock, rising edge
//   rst                         asynchronous reset, active low
//   aligned_pp_0..aligned_pp_8  signed partial products of one beat
//   exp_max                     signed group exponent, taken on the first beat
//   in_valid / in_ready         beat handshake
//   in_last                     beat closes the group
//   out_valid / out_ready       result handshake
//   out_sign, out_exp           result sign and signed exponent
//   out_mant                    normalized magnitude
//   out_beats                   number of beats in the group (1..256)

module accum_normalize (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aligned_pp_0,
  input  logic [15:0] aligned_pp_1,
  input  logic [15:0] aligned_pp_2,
  input  logic [15:0] aligned_pp_3,
  input  logic [15:0] aligned_pp_4,
  input  logic [15:0] aligned_pp_5,
  input  logic [15:0] aligned_pp_6,
  input  logic [15:0] aligned_pp_7,
  input  logic [15:0] aligned_pp_8,
  input  logic [4:0]  exp_max,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [6:0]  out_exp,
  output logic [10:0] out_mant,
  output logic [8:0]  out_beats
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]  r_state;
  logic [27:0] r_acc;
  logic [4:0]  r_exp_grp;
  logic [8:0]  r_beats;

  logic [19:0] w_beat_sum;
  logic [27:0] w_beat_ext;
  logic        w_accept;
  logic        w_last;
  logic [27:0] w_mag;
  logic [4:0]  w_msb;
  logic [10:0] w_mant;
  logic [6:0]  w_exp;

  assign w_beat_sum = {{4{aligned_pp_0[15]}}, aligned_pp_0} + {{4{aligned_pp_1[15]}}, aligned_pp_1}
                    + {{4{aligned_pp_2[15]}}, aligned_pp_2} + {{4{aligned_pp_3[15]}}, aligned_pp_3}
                    + {{4{aligned_pp_4[15]}}, aligned_pp_4} + {{4{aligned_pp_5[15]}}, aligned_pp_5}
                    + {{4{aligned_pp_6[15]}}, aligned_pp_6} + {{4{aligned_pp_7[15]}}, aligned_pp_7}
                    + {{4{aligned_pp_8[15]}}, aligned_pp_8};
  assign w_beat_ext = {{8{w_beat_sum[19]}}, w_beat_sum};

  assign in_ready  = (r_state == IDLE) || (r_state == ACC);
  assign out_valid = (r_state == OUT);
  assign w_accept  = in_valid && in_ready;
  // A beat arriving in ACC while 255 beats are already held is the 256th and
  // closes the group regardless of in_last.
  assign w_last    = in_last || ((r_state == ACC) && (r_beats == 9'd255));

  // The magnitude always fits in 27 bits, so the two's-complement negation is exact.
  assign w_mag = r_acc[27] ? (28'd0 - r_acc) : r_acc;

  always_comb begin
    w_msb = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (w_mag[i]) w_msb = i[4:0];
    end
  end

  // Bring the leading one to bit 10: right shift truncates, left shift zero-fills.
  always_comb begin
    w_mant = 11'd0;
    if (w_msb >= 5'd10) w_mant = 11'(w_mag >> (w_msb - 5'd10));
    else                w_mant = 11'(w_mag << (5'd10 - w_msb));
  end

  assign w_exp = {{2{r_exp_grp[4]}}, r_exp_grp} + {2'b00, w_msb} - 7'd11;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_acc     <= 28'd0;
      r_exp_grp <= 5'd0;
      r_beats   <= 9'd0;
      out_sign  <= 1'b0;
      out_exp   <= 7'd0;
      out_mant  <= 11'd0;
      out_beats <= 9'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc     <= w_beat_ext;
            r_exp_grp <= exp_max;
            r_beats   <= 9'd1;
            r_state   <= w_last ? NORM : ACC;
          end
        end
        ACC: begin
          if (w_accept) begin
            r_acc   <= r_acc + w_beat_ext;
            r_beats <= r_beats + 9'd1;
            r_state <= w_last ? NORM : ACC;
          end
        end
        NORM: begin
          if (w_mag == 28'd0) begin
            out_sign <= 1'b0;
            out_exp  <= 7'd0;
            out_mant <= 11'd0;
          end else begin
            out_sign <= r_acc[27];
            out_exp  <= w_exp;
            out_mant <= w_mant;
          end
          out_beats <= r_beats;
          r_state   <= OUT;
        end
        OUT: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_normalize.sv
// tb/tb_accum_normalize.sv - self-checking bench for accum_normalize against an arithmetic reference model

module tb_accum_normalize;

  logic               clk;
  logic               rst;
  logic signed [15:0] pp [9];
  logic [4:0]         exp_max;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic               out_sign;
  logic [6:0]         out_exp;
  logic [10:0]        out_mant;
  logic [8:0]         out_beats;

  int checks = 0;
  int errors = 0;

  longint m_sum;
  int     m_exp;
  int     m_beats;

  accum_normalize dut (
    .clk(clk), .rst(rst),
    .aligned_pp_0(pp[0]), .aligned_pp_1(pp[1]), .aligned_pp_2(pp[2]),
    .aligned_pp_3(pp[3]), .aligned_pp_4(pp[4]), .aligned_pp_5(pp[5]),
    .aligned_pp_6(pp[6]), .aligned_pp_7(pp[7]), .aligned_pp_8(pp[8]),
    .exp_max(exp_max), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant), .out_beats(out_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_pp();
    for (int k = 0; k < 9; k++) pp[k] = 16'sd0;
  endtask

  task automatic rand_pp();
    logic [31:0] v;
    for (int k = 0; k < 9; k++) begin
      v = $urandom;
      if (v[31:29] == 3'd0) pp[k] = 16'sd0;
      else pp[k] = $signed(v[15:0]) >>> $urandom_range(0, 15);
    end
  endtask

  task automatic model_reset();
    m_sum   = 0;
    m_exp   = 0;
    m_beats = 0;
  endtask

  // One beat offered at the falling edge, accepted at the next rising edge.
  task automatic beat(input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = last;
    chk("in_ready_beat", {31'd0, in_ready}, 32'd1);
    if (m_beats == 0) m_exp = int'($signed(exp_max));
    for (int k = 0; k < 9; k++) m_sum += longint'(pp[k]);
    m_beats++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference normalization straight from the arithmetic definition.
  task automatic expected(output logic e_sign, output logic [6:0] e_exp, output logic [10:0] e_mant);
    longint m;
    int     p;
    int     e;
    if (m_sum == 0) begin
      e_sign = 1'b0;
      e_exp  = 7'd0;
      e_mant = 11'd0;
    end else begin
      e_sign = (m_sum < 0);
      m = (m_sum < 0) ? -m_sum : m_sum;
      p = 0;
      while (m >= (longint'(2) ** (p + 1))) p++;
      if (p >= 10) m = m / (longint'(2) ** (p - 10));
      else         m = m * (longint'(2) ** (10 - p));
      e      = m_exp + p - 11;
      e_exp  = 7'(e);
      e_mant = 11'(m);
    end
  endtask

  task automatic check_fields(input string tag);
    logic        e_sign;
    logic [6:0]  e_exp;
    logic [10:0] e_mant;
    expected(e_sign, e_exp, e_mant);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sign"},  {31'd0, out_sign},  {31'd0, e_sign});
    chk({tag, "_exp"},   {25'd0, out_exp},   {25'd0, e_exp});
    chk({tag, "_mant"},  {21'd0, out_mant},  {21'd0, e_mant});
    chk({tag, "_beats"}, {23'd0, out_beats}, 32'(m_beats));
  endtask

  // Called right after the edge that accepted the closing beat.
  task automatic finish_group(input string tag, input int hold);
    chk({tag, "_norm_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_norm_ready"}, {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    rand_pp();
    @(posedge clk);
    #1;
    check_fields(tag);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      check_fields({tag, "_hold"});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    model_reset();
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    exp_max   = 5'd0;
    clear_pp();
    model_reset();
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sign",  {31'd0, out_sign},  32'd0);
    chk("rst_exp",   {25'd0, out_exp},   32'd0);
    chk("rst_mant",  {21'd0, out_mant},  32'd0);
    chk("rst_beats", {23'd0, out_beats}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_release_ready", {31'd0, in_ready}, 32'd1);

    // Single beat of +1.75-style value.
    clear_pp();
    pp[0] = 16'sh3800;
    exp_max = 5'd2;
    beat(1'b1);
    finish_group("single", 0);

    // Two negative beats.
    clear_pp();
    pp[0] = 16'shC800;
    exp_max = 5'd0;
    beat(1'b0);
    exp_max = 5'd9;
    beat(1'b1);
    finish_group("two_neg", 1);

    // Group cancelling to zero.
    clear_pp();
    pp[0] = 16'sh0800;
    exp_max = 5'd3;
    beat(1'b0);
    pp[0] = -16'sh0800;
    beat(1'b1);
    finish_group("zero", 0);

    // Output stall with in_valid asserted throughout.
    clear_pp();
    pp[4] = 16'sh0013;
    exp_max = 5'h1C;
    beat(1'b1);
    finish_group("stall", 5);

    // Forced close at 256 beats; in_last never asserted.
    exp_max = 5'd5;
    for (int b = 0; b < 256; b++) begin
      rand_pp();
      beat(1'b0);
      exp_max = 5'($urandom);
    end
    finish_group("max256", 2);

    // Reset during ACC discards the partial group.
    exp_max = 5'd1;
    for (int b = 0; b < 3; b++) begin
      rand_pp();
      beat(1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_acc_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acc_beats", {23'd0, out_beats}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    clear_pp();
    pp[2] = 16'sh0101;
    pp[7] = -16'sh0005;
    exp_max = 5'd7;
    beat(1'b1);
    finish_group("after_rst", 0);

    // Reset while a result is waiting in OUT.
    rand_pp();
    exp_max = 5'd4;
    beat(1'b1);
    @(posedge clk);
    #1;
    chk("out_pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_mant",  {21'd0, out_mant},  32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Randomized groups with random exponents, lengths and stalls.
    for (int g = 0; g < 25; g++) begin
      int n;
      n = $urandom_range(1, 12);
      exp_max = 5'($urandom);
      for (int b = 0; b < n; b++) begin
        rand_pp();
        beat(b == n - 1);
        exp_max = 5'($urandom);
      end
      finish_group("rand", $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
